onehot_led_sequencer: RTL and testbench



---
 rtl/onehot_led_sequencer.sv | 139 +++++++++++++
 tb/tb_onehot_led_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_led_sequencer.sv
// One-hot LED sequencer: a registered position index stepped by a prescaled
// tick in static, rotate-up, rotate-down or bounce mode. The one-hot vector q
// is registered alongside idx so the LED pins never see decode glitches.
module onehot_led_sequencer #(
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DIV   = 5000000,
  parameter int unsigned DIV_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [SEL_W-1:0] load_idx,
  output logic [N-1:0]     q,
  output logic [SEL_W-1:0] idx,
  output logic             dir,
  output logic             step
);

  // Reject illegal parameter combinations at elaboration.
  if (N < 2 || N > 256) begin : g_bad_n
    $error("onehot_led_sequencer: N must be in 2..256");
  end
  if (SEL_W != $clog2(N)) begin : g_bad_sel_w
    $error("onehot_led_sequencer: SEL_W must equal clog2(N)");
  end
  if (DIV < 1 || longint'(DIV) > (longint'(1) << DIV_W)) begin : g_bad_div
    $error("onehot_led_sequencer: DIV must be in 1..2**DIV_W");
  end

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV - 1);
  localparam logic [SEL_W-1:0] IdxMax  = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] IdxMaxM1 = SEL_W'(N - 2);
  // One bit wider than the index so N itself is representable (N=256).
  localparam logic [SEL_W:0]   NFull   = (SEL_W + 1)'(N);

  typedef enum logic [1:0] {
    ModeStatic = 2'b00,
    ModeUp     = 2'b01,
    ModeDown   = 2'b10,
    ModeBounce = 2'b11
  } mode_e;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N-1:0]     q_q, q_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             tick;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);

  // State registers; q is registered with idx rather than decoded from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      q_q    <= N'(1);
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      q_q    <= q_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  // Next state: load beats tick beats hold; mode only matters on a tick.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    dir_d = dir_q;
    tick  = 1'b0;

    if (load) begin
      cnt_d = '0;
      dir_d = 1'b0;
      if ({1'b0, load_idx} >= NFull) begin
        idx_d = IdxMax;
      end else begin
        idx_d = load_idx;
      end
    end else if (en) begin
      if (cnt_q == DivLast) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end

      if (tick) begin
        unique case (mode_sel)
          ModeStatic: ;
          ModeUp: begin
            dir_d = 1'b0;
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + SEL_W'(1);
          end
          ModeDown: begin
            dir_d = 1'b1;
            idx_d = (idx_q == '0) ? IdxMax : idx_q - SEL_W'(1);
          end
          ModeBounce: begin
            // Turn around on the endpoint so it is lit for one tick only.
            if (!dir_q) begin
              if (idx_q == IdxMax) begin
                dir_d = 1'b1;
                idx_d = IdxMaxM1;
              end else begin
                idx_d = idx_q + SEL_W'(1);
              end
            end else begin
              if (idx_q == '0) begin
                dir_d = 1'b0;
                idx_d = SEL_W'(1);
              end else begin
                idx_d = idx_q - SEL_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end

    q_d    = N'(1) << idx_d;
    step_d = tick;
  end

  assign q    = q_q;
  assign idx  = idx_q;
  assign dir  = dir_q;
  assign step = step_q;

endmodule

// File: tb/tb_onehot_led_sequencer.sv
// Directed bench for onehot_led_sequencer. Three instances share one set of
// inputs: A (N=8, DIV=4), B (N=5, DIV=4) and C (N=5, DIV=1).
module tb_onehot_led_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_idx;

  logic [7:0] q_a;
  logic [2:0] idx_a;
  logic       dir_a, step_a;
  logic [4:0] q_b;
  logic [2:0] idx_b;
  logic       dir_b, step_b;
  logic [4:0] q_c;
  logic [2:0] idx_c;
  logic       dir_c, step_c;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned bnc_idx[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
  bit          bnc_dir[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  onehot_led_sequencer #(.N(8), .SEL_W(3), .DIV(4), .DIV_W(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_idx(load_idx),
    .q(q_a), .idx(idx_a), .dir(dir_a), .step(step_a)
  );

  onehot_led_sequencer #(.N(5), .SEL_W(3), .DIV(4), .DIV_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_idx(load_idx),
    .q(q_b), .idx(idx_b), .dir(dir_b), .step(step_b)
  );

  onehot_led_sequencer #(.N(5), .SEL_W(3), .DIV(1), .DIV_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_idx(load_idx),
    .q(q_c), .idx(idx_c), .dir(dir_c), .step(step_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given controls, release between edges.
  task automatic do_reset(input logic en_v, input logic [1:0] mode_v);
    rst_n    = 1'b0;
    en       = en_v;
    mode     = mode_v;
    load     = 1'b0;
    load_idx = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 2'b01);
    n_tests++;
    if (q_a !== 8'h01 || idx_a !== 3'd0 || dir_a !== 1'b0 || step_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: q=%h idx=%0d dir=%b step=%b, want q=01 idx=0 dir=0 step=0",
               q_a, idx_a, dir_a, step_a);
    end
    n_tests++;
    if (q_b !== 5'h01 || idx_b !== 3'd0 || q_c !== 5'h01 || step_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bc: q_b=%h idx_b=%0d q_c=%h step_c=%b, want 01 0 01 0",
               q_b, idx_b, q_c, step_c);
    end
  endtask

  task automatic test_rotate_up();
    do_reset(1'b1, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      for (int e = 0; e < 3; e++) begin
        cyc();
        n_tests++;
        if (step_a !== 1'b0) begin
          n_fail++;
          $display("FAIL up_nostep k=%0d e=%0d: step=%b, want 0", k, e, step_a);
        end
      end
      cyc();
      n_tests++;
      if (step_a !== 1'b1 || q_a !== (8'h01 << (k % 8)) || dir_a !== 1'b0) begin
        n_fail++;
        $display("FAIL up_tick k=%0d: step=%b q=%h dir=%b, want 1 %h 0",
                 k, step_a, q_a, dir_a, 8'h01 << (k % 8));
      end
    end
  endtask

  task automatic test_rotate_down();
    do_reset(1'b1, 2'b10);
    repeat (4) cyc();
    n_tests++;
    if (step_a !== 1'b1 || idx_a !== 3'd7 || q_a !== 8'h80 || dir_a !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: step=%b idx=%0d q=%h dir=%b, want 1 7 80 1",
               step_a, idx_a, q_a, dir_a);
    end
    repeat (4) cyc();
    n_tests++;
    if (idx_a !== 3'd6 || q_a !== 8'h40 || dir_a !== 1'b1) begin
      n_fail++;
      $display("FAIL down_next: idx=%0d q=%h dir=%b, want 6 40 1", idx_a, q_a, dir_a);
    end
  endtask

  task automatic test_bounce();
    do_reset(1'b1, 2'b11);
    for (int k = 0; k < 9; k++) begin
      cyc();
      n_tests++;
      if (idx_c !== 3'(bnc_idx[k]) || q_c !== (5'h01 << bnc_idx[k]) ||
          dir_c !== bnc_dir[k] || step_c !== 1'b1) begin
        n_fail++;
        $display("FAIL bounce k=%0d: idx=%0d q=%h dir=%b step=%b, want %0d %h %b 1",
                 k, idx_c, q_c, dir_c, step_c, bnc_idx[k], 5'h01 << bnc_idx[k], bnc_dir[k]);
      end
    end
  endtask

  task automatic test_load_clamp();
    do_reset(1'b1, 2'b01);
    repeat (3) cyc();
    // Prescaler now sits at DIV-1; the load must swallow this tick.
    load     = 1'b1;
    load_idx = 3'd2;
    cyc();
    load = 1'b0;
    n_tests++;
    if (idx_b !== 3'd2 || q_b !== 5'h04 || step_b !== 1'b0 || dir_b !== 1'b0) begin
      n_fail++;
      $display("FAIL load_coincident: idx=%0d q=%h step=%b dir=%b, want 2 04 0 0",
               idx_b, q_b, step_b, dir_b);
    end
    repeat (3) cyc();
    n_tests++;
    if (step_b !== 1'b0 || idx_b !== 3'd2) begin
      n_fail++;
      $display("FAIL load_wait: step=%b idx=%0d, want 0 2", step_b, idx_b);
    end
    cyc();
    n_tests++;
    if (step_b !== 1'b1 || idx_b !== 3'd3 || q_b !== 5'h08) begin
      n_fail++;
      $display("FAIL load_next_tick: step=%b idx=%0d q=%h, want 1 3 08", step_b, idx_b, q_b);
    end
    load     = 1'b1;
    load_idx = 3'd7;
    cyc();
    load = 1'b0;
    n_tests++;
    if (idx_b !== 3'd4 || q_b !== 5'h10 || step_b !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: idx=%0d q=%h step=%b, want 4 10 0", idx_b, q_b, step_b);
    end
  endtask

  task automatic test_enable_static();
    do_reset(1'b1, 2'b01);
    repeat (2) cyc();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      n_tests++;
      if (step_a !== 1'b0 || idx_a !== 3'd0 || q_a !== 8'h01) begin
        n_fail++;
        $display("FAIL freeze k=%0d: step=%b idx=%0d q=%h, want 0 0 01", k, step_a, idx_a, q_a);
      end
    end
    en = 1'b1;
    cyc();
    n_tests++;
    if (step_a !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_early: step=%b, want 0", step_a);
    end
    cyc();
    n_tests++;
    if (step_a !== 1'b1 || idx_a !== 3'd1 || q_a !== 8'h02) begin
      n_fail++;
      $display("FAIL resume_tick: step=%b idx=%0d q=%h, want 1 1 02", step_a, idx_a, q_a);
    end
    mode = 2'b00;
    repeat (4) cyc();
    n_tests++;
    if (step_a !== 1'b1 || idx_a !== 3'd1 || q_a !== 8'h02 || dir_a !== 1'b0) begin
      n_fail++;
      $display("FAIL static_tick: step=%b idx=%0d q=%h dir=%b, want 1 1 02 0",
               step_a, idx_a, q_a, dir_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1, 2'b11);
    repeat (5) cyc();
    n_tests++;
    if (idx_c !== 3'd3 || dir_c !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: idx=%0d dir=%b, want 3 1", idx_c, dir_c);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (q_c !== 5'h01 || idx_c !== 3'd0 || dir_c !== 1'b0 || step_c !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: q=%h idx=%0d dir=%b step=%b, want 01 0 0 0",
               q_c, idx_c, dir_c, step_c);
    end
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    n_tests++;
    if (step_a !== 1'b0 || idx_a !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_wait: step=%b idx=%0d, want 0 0", step_a, idx_a);
    end
    cyc();
    n_tests++;
    if (step_a !== 1'b1 || q_a !== 8'h02 || dir_a !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_tick: step=%b q=%h dir=%b, want 1 02 0", step_a, q_a, dir_a);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 2'b00;
    load     = 1'b0;
    load_idx = '0;
    test_reset();
    test_rotate_up();
    test_rotate_down();
    test_bounce();
    test_load_clamp();
    test_enable_static();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
